// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - 3-stage pipelined floating-point multiplier with stall.
// Denormal inputs flush to zero; round to nearest even; tiny results flush to zero.
module fmul_pipe #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [EW+MW:0]  x1,
   input  logic [EW+MW:0]  x2,
   input  logic            in_valid,
   input  logic            stall,
   output logic [EW+MW:0]  y,
   output logic            out_valid,
   output logic            ovf,
   output logic            unf,
   output logic            nv
);
   localparam int W    = 1 + EW + MW;
   localparam int BIAS = 2**(EW-1) - 1;
   localparam int PW   = 2 * (MW + 1);
   localparam int EMAX = 2**EW - 1;
   localparam logic signed [EW+1:0] BIAS_S = BIAS[EW+1:0];
   localparam logic signed [EW+1:0] EMAX_S = EMAX[EW+1:0];
   localparam logic signed [EW+1:0] EZERO  = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;

   // stage 1: classify operands and sum exponents
   logic [EW-1:0]          ea, eb;
   logic [MW-1:0]          fa, fb;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   cls_t                   cls1_d, cls1_q;
   logic signed [EW+1:0]   e1_d, e1_q;
   logic [MW:0]            ma1_q, mb1_q;
   logic                   s1_q, v1_q;

   always_comb begin
      ea     = x1[W-2:MW];
      eb     = x2[W-2:MW];
      fa     = x1[MW-1:0];
      fb     = x2[MW-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (&ea) && (fa == '0);
      b_inf  = (&eb) && (fb == '0);
      a_nan  = (&ea) && (fa != '0);
      b_nan  = (&eb) && (fb != '0);
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) cls1_d = C_NAN;
      else if (a_inf || b_inf)                                      cls1_d = C_INF;
      else if (a_zero || b_zero)                                    cls1_d = C_ZERO;
      else                                                          cls1_d = C_NORM;
      e1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
   end

   // stage 2: significand product
   logic [PW-1:0]          prod_d, prod2_q;
   cls_t                   cls2_q;
   logic signed [EW+1:0]   e2_q;
   logic                   s2_q, v2_q;

   assign prod_d = {{(MW+1){1'b0}}, ma1_q} * {{(MW+1){1'b0}}, mb1_q};

   // stage 3: normalize, round, range check, pack
   logic                   msb, guard, sticky, rnd;
   logic [PW-1:0]          norm;
   logic [MW:0]            sig;
   logic [MW+1:0]          sig_r;
   logic [MW-1:0]          frac;
   logic signed [EW+1:0]   e_r;
   logic [W-1:0]           y_d, y_q;
   logic                   ov_d, ov_q, ovf_d, ovf_q, unf_d, unf_q, nv_d, nv_q;

   always_comb begin
      y_d    = '0;
      ov_d   = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      nv_d   = 1'b0;
      msb    = prod2_q[PW-1];
      norm   = msb ? prod2_q : {prod2_q[PW-2:0], 1'b0};
      sig    = norm[PW-1:PW-1-MW];
      guard  = norm[PW-2-MW];
      sticky = |norm[PW-3-MW:0];
      rnd    = guard & (sticky | sig[0]);
      sig_r  = {1'b0, sig} + {{(MW+1){1'b0}}, rnd};
      // a rounding carry leaves sig_r = 2^(MW+1): fraction becomes zero, exponent bumps
      frac   = sig_r[MW+1] ? sig_r[MW:1] : sig_r[MW-1:0];
      e_r    = e2_q + $signed({{(EW+1){1'b0}}, msb}) + $signed({{(EW+1){1'b0}}, sig_r[MW+1]});
      if (v2_q) begin
         ov_d = 1'b1;
         case (cls2_q)
            C_NAN: begin
               y_d  = QNAN;
               nv_d = 1'b1;
            end
            C_INF:  y_d = {s2_q, {EW{1'b1}}, {MW{1'b0}}};
            C_ZERO: y_d = {s2_q, {(W-1){1'b0}}};
            default: begin
               if (e_r >= EMAX_S) begin
                  y_d   = {s2_q, {EW{1'b1}}, {MW{1'b0}}};
                  ovf_d = 1'b1;
               end else if (e_r <= EZERO) begin
                  y_d   = {s2_q, {(W-1){1'b0}}};
                  unf_d = 1'b1;
               end else begin
                  y_d = {s2_q, e_r[EW-1:0], frac};
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q    <= 1'b0;
         s1_q    <= 1'b0;
         e1_q    <= '0;
         ma1_q   <= '0;
         mb1_q   <= '0;
         cls1_q  <= C_NORM;
         v2_q    <= 1'b0;
         s2_q    <= 1'b0;
         e2_q    <= '0;
         prod2_q <= '0;
         cls2_q  <= C_NORM;
         y_q     <= '0;
         ov_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         nv_q    <= 1'b0;
      end else if (!stall) begin
         v1_q    <= in_valid;
         s1_q    <= x1[W-1] ^ x2[W-1];
         e1_q    <= e1_d;
         ma1_q   <= {1'b1, fa};
         mb1_q   <= {1'b1, fb};
         cls1_q  <= cls1_d;
         v2_q    <= v1_q;
         s2_q    <= s1_q;
         e2_q    <= e1_q;
         prod2_q <= prod_d;
         cls2_q  <= cls1_q;
         y_q     <= y_d;
         ov_q    <= ov_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         nv_q    <= nv_d;
      end
   end

   assign y         = y_q;
   assign out_valid = ov_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;
   assign nv        = nv_q;
endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - randomized and directed checks of fmul_pipe against a behavioural model.
module tb_fmul_pipe;
   logic        clk = 1'b0;
   logic        rstn, in_valid, stall;
   logic [31:0] x1, x2, y;
   logic        out_valid, ovf, unf, nv;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   fmul_pipe #(.EW(8), .MW(23)) dut (
      .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid), .stall(stall),
      .y(y), .out_valid(out_valid), .ovf(ovf), .unf(unf), .nv(nv)
   );

   // reference product as {nv, unf, ovf, y}, exact integer product then remainder-based rounding
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, msb, sh;
      longint unsigned p, q, rem, half;
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      s      = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return {3'b100, 32'h7FC00000};
      if (a_inf || b_inf) return {3'b000, s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {3'b000, s, 31'd0};
      p   = (64'(a[22:0]) | (64'd1 << 23)) * (64'(b[22:0]) | (64'd1 << 23));
      msb = 47;
      while (((p >> msb) & 64'd1) == 64'd0) msb--;
      e    = ea + eb - 127 + (msb - 46);
      sh   = msb - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) return {3'b001, s, 8'hFF, 23'd0};
      if (e <= 0) return {3'b010, s, 31'd0};
      return {3'b000, s, 8'(e), q[22:0]};
   endfunction

   task automatic chk(input string nm, input logic [34:0] got, input logic [34:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got flags=%b y=%h, expected flags=%b y=%h", nm, got[34:32], got[31:0], exp[34:32], exp[31:0]);
      end
   endtask

   // expected output stream: one slot per pipeline stage, advanced on enabled edges only
   logic [35:0] pipe [3];
   logic [34:0] got_q [$];

   always @(posedge clk) begin
      logic st;
      st = stall;
      if (!rstn) begin
         for (int i = 0; i < 3; i++) pipe[i] = '0;
      end else if (!st) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = in_valid ? {1'b1, model(x1, x2)} : 36'd0;
      end
      #1;
      tests++;
      if ({out_valid, nv, unf, ovf, y} !== pipe[2]) begin
         fails++;
         $display("FAIL cycle_out t=%0t: got v=%b f=%b%b%b y=%h, expected v=%b f=%b y=%h",
                  $time, out_valid, nv, unf, ovf, y, pipe[2][35], pipe[2][34:32], pipe[2][31:0]);
      end
      if (rstn && !st && out_valid) got_q.push_back({nv, unf, ovf, y});
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      x1 = a;
      x2 = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_count(input string nm, input int exp_n);
      tests++;
      if (got_q.size() != exp_n) begin
         fails++;
         $display("FAIL %s: got %0d results, expected %0d", nm, got_q.size(), exp_n);
      end
   endtask

   function automatic logic [31:0] rnd_op();
      int k;
      logic [7:0] e;
      logic [22:0] f;
      k = $urandom_range(0, 9);
      f = 23'($urandom);
      case (k)
         0:       e = 8'h00;
         1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
         2:       e = 8'($urandom_range(1, 30));
         3:       e = 8'($urandom_range(225, 254));
         default: e = 8'($urandom_range(100, 154));
      endcase
      if ($urandom_range(0, 7) == 0) f = '1;
      return {1'($urandom), e, f};
   endfunction

   initial begin
      int n;
      rstn = 1'b0;
      in_valid = 1'b0;
      stall = 1'b0;
      x1 = '0;
      x2 = '0;

      chk("m_basic",  model(32'h40000000, 32'h40400000), {3'b000, 32'h40C00000});
      chk("m_round",  model(32'h3F800001, 32'h3F800001), {3'b000, 32'h3F800002});
      chk("m_b2b",    model(32'h3FC00000, 32'h3FC00000), {3'b000, 32'h40100000});
      chk("m_tie_up", model(32'h3F800001, 32'h3F400000), {3'b000, 32'h3F400002});
      chk("m_tie_ev", model(32'h3F800003, 32'h3FC00000), {3'b000, 32'h3FC00004});
      chk("m_ovf",    model(32'h7F000000, 32'h40000000), {3'b001, 32'h7F800000});
      chk("m_unf",    model(32'h00800000, 32'h3F000000), {3'b010, 32'h00000000});
      chk("m_unf_n",  model(32'h80800000, 32'h3F000000), {3'b010, 32'h80000000});
      chk("m_nv",     model(32'h7F800000, 32'h00000000), {3'b100, 32'h7FC00000});
      chk("m_inf",    model(32'hFF800000, 32'h40000000), {3'b000, 32'hFF800000});

      idle(3);
      tests++;
      if ({out_valid, ovf, unf, nv, y} !== 36'd0) begin
         fails++;
         $display("FAIL reset_state: got v=%b y=%h, expected all zero", out_valid, y);
      end

      // first edge after release must accept
      rstn = 1'b1;
      x1 = 32'h40000000;
      x2 = 32'h40400000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++;
      if (n != 3 || y !== 32'h40C00000 || {ovf, unf, nv} !== 3'b000) begin
         fails++;
         $display("FAIL latency: got %0d cycles y=%h, expected 3 cycles y=40c00000", n, y);
      end
      @(negedge clk);
      idle(4);

      got_q.delete();
      send(32'h3F800001, 32'h3F800001);
      send(32'h3FC00000, 32'h3FC00000);
      idle(5);
      chk_count("b2b_count", 2);
      if (got_q.size() == 2) begin
         chk("b2b_0", got_q[0], {3'b000, 32'h3F800002});
         chk("b2b_1", got_q[1], {3'b000, 32'h40100000});
      end

      got_q.delete();
      send(32'h7F000000, 32'h40000000);
      send(32'h00800000, 32'h3F000000);
      send(32'h80800000, 32'h3F000000);
      send(32'h7F800000, 32'h00000000);
      send(32'hFF800000, 32'h40000000);
      idle(5);
      chk_count("range_count", 5);
      if (got_q.size() == 5) begin
         chk("ovf", got_q[0], {3'b001, 32'h7F800000});
         chk("unf", got_q[1], {3'b010, 32'h00000000});
         chk("unf_neg", got_q[2], {3'b010, 32'h80000000});
         chk("nv", got_q[3], {3'b100, 32'h7FC00000});
         chk("inf", got_q[4], {3'b000, 32'hFF800000});
      end

      got_q.delete();
      send(32'h40000000, 32'h40400000);
      send(32'h3FC00000, 32'h3FC00000);
      send(32'h3F800003, 32'h3FC00000);
      stall = 1'b1;
      in_valid = 1'b1;
      x1 = 32'h40000000;
      x2 = 32'h40000000;
      idle(4);
      stall = 1'b0;
      in_valid = 1'b0;
      idle(6);
      chk_count("stall_count", 3);
      if (got_q.size() == 3) begin
         chk("stall_0", got_q[0], {3'b000, 32'h40C00000});
         chk("stall_1", got_q[1], {3'b000, 32'h40100000});
         chk("stall_2", got_q[2], {3'b000, 32'h3FC00004});
      end

      send(32'h40000000, 32'h40400000);
      send(32'h3FC00000, 32'h3FC00000);
      rstn = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: got out_valid=%b, expected 0", out_valid);
      end
      @(negedge clk);
      rstn = 1'b1;
      got_q.delete();
      idle(6);
      chk_count("reset_flush", 0);

      for (int i = 0; i < 3000; i++) begin
         x1 = rnd_op();
         x2 = rnd_op();
         in_valid = ($urandom_range(0, 3) != 0);
         stall = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      stall = 1'b0;
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width in bits.
REQ-002 SHALL have parameter MW, default 23, stored mantissa (fraction) width in bits.
REQ-003 SHALL derive W = 1+EW+MW and BIAS = 2^(EW-1)-1 as localparams.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port x1  input  W  operand A, {sign, exponent, fraction}.
REQ-007 SHALL have port x2  input  W  operand B, same format.
REQ-008 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-009 SHALL have port stall  input  1  freezes the whole pipeline while high.
REQ-010 SHALL have port y  output  W  product, registered.
REQ-011 SHALL have port out_valid  output  1  y and flags valid, registered.
REQ-012 SHALL have port ovf  output  1  result overflowed to infinity.
REQ-013 SHALL have port unf  output  1  result underflowed and was flushed to zero.
REQ-014 SHALL have port nv  output  1  invalid operation; NaN produced.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent sum; S2 (MW+1)x(MW+1) significand multiply; S3 normalize/round/pack into output registers.
REQ-016 SHALL present a result on y/out_valid exactly 3 enabled cycles after in_valid is sampled high, with stall low at the sampling edge.
REQ-017 SHALL accept one operation per cycle; a valid bit travels with each stage.
REQ-018 SHALL hold every pipeline register, including y, out_valid and the flags, unchanged in any cycle where stall=1; in_valid is ignored in that cycle.
REQ-019 SHALL compute sign = s1 XOR s2 for all results, including zero, infinity and NaN.
REQ-020 SHALL treat any input with exponent 0 as signed zero (denormal inputs flushed to zero, no flag).
REQ-021 SHALL form the exponent as e1 + e2 - BIAS in EW+2-bit signed arithmetic; no truncation before the range checks.
REQ-022 SHALL normalize a 2(MW+1)-bit product: if the product MSB is 1, shift right 1 and increment the exponent.
REQ-023 SHALL round to nearest, ties to even, using guard bit plus sticky OR of all lower bits.
REQ-024 SHALL, when rounding carries out of the significand, renormalize and increment the exponent before the range checks.
REQ-025 SHALL, when the final exponent is >= 2^EW-1, output signed infinity and set ovf=1.
REQ-026 SHALL, when the final exponent is <= 0, output signed zero and set unf=1.
REQ-027 SHALL, when either input is NaN, or infinity x zero occurs, output canonical NaN {0, all-ones exponent, fraction MSB 1, rest 0} and set nv=1.
REQ-028 SHALL output signed infinity with no flags for infinity x finite nonzero or infinity x infinity.
REQ-029 SHALL output signed zero with no flags for zero x finite.
REQ-030 SHALL raise at most one of ovf/unf/nv per result; flags are valid only with out_valid=1 and are 0 otherwise.
REQ-031 SHALL drive y to 0 in cycles where out_valid is 0 and stall is 0.

Reset
REQ-032 SHALL, while rstn=0, asynchronously clear y, out_valid, ovf, unf, nv and all stage valid bits to 0.
REQ-033 SHALL discard operations in flight on reset; no out_valid pulse follows reset release unless new in_valid is sampled.
REQ-034 SHALL accept in_valid on the first rising edge after rstn deasserts.

Verification (EW=8, MW=23)
REQ-035 Basic: x1=0x40000000, x2=0x40400000, in_valid=1 for one cycle -> 3 cycles later y=0x40C00000, out_valid=1, flags 0.
REQ-036 Rounding/back-to-back: 0x3F800001*0x3F800001, then 0x3FC00000*0x3FC00000 on consecutive cycles -> consecutive outputs 0x3F800002, then 0x40100000.
REQ-037 Range: 0x7F000000*0x40000000 -> 0x7F800000 with ovf=1; 0x00800000*0x3F000000 -> 0x00000000 with unf=1; 0x80800000*0x3F000000 -> 0x80000000 with unf=1.
REQ-038 Specials: 0x7F800000*0x00000000 -> 0x7FC00000 with nv=1; 0xFF800000*0x40000000 -> 0xFF800000 with flags 0.
REQ-039 Stall: issue 3 ops, hold stall=1 for 4 cycles mid-flight -> outputs frozen during stall; all 3 results emerge in order, none lost or duplicated.
REQ-040 Reset mid-op: pulse rstn low 1 cycle with 2 ops in flight -> out_valid=0 immediately, no stale result after release.
